// File: rtl/bus_master_axi_pkg.sv
// Shared types and constants for the AXI-Lite bus master.
package bus_master_axi_pkg;

    // Transaction sequencer states: one outstanding transaction at a time.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_RSP     = 3'd5
    } state_t;

    // AXI response codes as carried on BRESP/RRESP.
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Unprivileged, secure, data access on every request.
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    // True while a transaction is out on the AXI bus awaiting completion.
    function automatic logic state_is_busy(input state_t s);
        return (s == ST_WR_REQ) || (s == ST_WR_RESP) ||
               (s == ST_RD_REQ) || (s == ST_RD_RESP);
    endfunction

endpackage

// File: rtl/bus_master_timer.sv
// Saturating cycle counter used to flag slow AXI transactions.
// expired_o stays high once the limit is reached until clear_i.
module bus_master_timer #(
    parameter int C_TIMEOUT = 1024
) (
    input  logic ACLK,
    input  logic ARESETN,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = $clog2(C_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(C_TIMEOUT);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, otherwise count up while enabled and hold at the limit.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with asynchronous reset.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/bus_master_axi.sv
// Simple command/response front end driving an AXI-Lite master port.
// Accepts one command, runs it on AXI, returns a response, then accepts
// the next. All AXI VALIDs are registered, so they never depend on READY.
module bus_master_axi
    import bus_master_axi_pkg::*;
#(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_TIMEOUT    = 1024
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,

    // Command side
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_wr,
    input  logic [C_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_DATA_WIDTH/8-1:0] cmd_wstrb,

    // Response side
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_wr,
    output logic [C_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      rsp_timeout,

    // AXI-Lite write address
    output logic [C_ADDR_WIDTH-1:0]   AWADDR,
    output logic [2:0]                AWPROT,
    output logic                      AWVALID,
    input  logic                      AWREADY,

    // AXI-Lite write data
    output logic [C_DATA_WIDTH-1:0]   WDATA,
    output logic [C_DATA_WIDTH/8-1:0] WSTRB,
    output logic                      WVALID,
    input  logic                      WREADY,

    // AXI-Lite write response
    input  logic [1:0]                BRESP,
    input  logic                      BVALID,
    output logic                      BREADY,

    // AXI-Lite read address
    output logic [C_ADDR_WIDTH-1:0]   ARADDR,
    output logic [2:0]                ARPROT,
    output logic                      ARVALID,
    input  logic                      ARREADY,

    // AXI-Lite read data
    input  logic [C_DATA_WIDTH-1:0]   RDATA,
    input  logic [1:0]                RRESP,
    input  logic                      RVALID,
    output logic                      RREADY
);

    localparam int C_STRB_WIDTH = C_DATA_WIDTH / 8;

    // Sequencer state and per-channel VALID flags.
    state_t state_q, state_d;
    logic   awvalid_q, awvalid_d;
    logic   wvalid_q,  wvalid_d;
    logic   arvalid_q, arvalid_d;

    // Command payload, captured only on accept so AXI payload stays stable.
    logic [C_ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [C_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [C_STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic                    wr_q,    wr_d;

    // Response payload captured from B or R.
    logic [C_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]              resp_q,  resp_d;

    logic cmd_accept;
    logic busy;
    logic timer_expired;

    // A command is taken only in IDLE; anything offered elsewhere is ignored.
    assign cmd_accept = (state_q == ST_IDLE) && cmd_valid;
    assign busy       = state_is_busy(state_q);

    // Next-state and datapath update for the transaction sequencer.
    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wr_d      = wr_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    wr_d    = cmd_wr;
                    if (cmd_wr) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_REQ;
                    end
                end
            end

            ST_WR_REQ: begin
                // AW and W complete independently, in either order.
                if (awvalid_q && AWREADY) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && WREADY) begin
                    wvalid_d = 1'b0;
                end
                if ((!awvalid_q || AWREADY) && (!wvalid_q || WREADY)) begin
                    state_d = ST_WR_RESP;
                end
            end

            ST_WR_RESP: begin
                if (BVALID) begin
                    resp_d  = BRESP;
                    rdata_d = '0;
                    state_d = ST_RSP;
                end
            end

            ST_RD_REQ: begin
                if (ARREADY) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_RD_RESP;
                end
            end

            ST_RD_RESP: begin
                if (RVALID) begin
                    resp_d  = RRESP;
                    rdata_d = RDATA;
                    state_d = ST_RSP;
                end
            end

            ST_RSP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                arvalid_d = 1'b0;
            end
        endcase
    end

    // State and payload registers; reset drops every VALID/READY at once.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= ST_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wr_q      <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= AXI_RESP_OKAY;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wr_q      <= wr_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

    // Watchdog on the AXI leg of the transaction; flag only, never aborts.
    bus_master_timer #(
        .C_TIMEOUT (C_TIMEOUT)
    ) u_timer (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .clear_i   (cmd_accept),
        .enable_i  (busy),
        .expired_o (timer_expired)
    );

    // cmd_ready is held low while reset is asserted.
    assign cmd_ready   = (state_q == ST_IDLE) && ARESETN;

    assign rsp_valid   = (state_q == ST_RSP);
    assign rsp_wr      = wr_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_resp    = resp_q;
    assign rsp_timeout = timer_expired;

    assign AWADDR  = addr_q;
    assign AWPROT  = AXI_PROT_DEFAULT;
    assign AWVALID = awvalid_q;

    assign WDATA   = wdata_q;
    assign WSTRB   = wstrb_q;
    assign WVALID  = wvalid_q;

    assign BREADY  = (state_q == ST_WR_RESP);

    assign ARADDR  = addr_q;
    assign ARPROT  = AXI_PROT_DEFAULT;
    assign ARVALID = arvalid_q;

    assign RREADY  = (state_q == ST_RD_RESP);

endmodule

// File: tb/tb_bus_master_axi.sv
// Directed bench for bus_master_axi with a response scoreboard and
// AXI VALID stability monitor.
module tb_bus_master_axi;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 16;

    logic          ACLK = 1'b0;
    logic          ARESETN;
    logic          cmd_valid, cmd_ready, cmd_wr;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic          rsp_valid, rsp_ready, rsp_wr, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] AWADDR, ARADDR;
    logic [2:0]    AWPROT, ARPROT;
    logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic          ARVALID, ARREADY, RVALID, RREADY;
    logic [DW-1:0] WDATA, RDATA;
    logic [3:0]    WSTRB;
    logic [1:0]    BRESP, RRESP;

    always #5 ACLK = ~ACLK;

    bus_master_axi #(
        .C_DATA_WIDTH (DW),
        .C_ADDR_WIDTH (AW),
        .C_TIMEOUT    (TO)
    ) dut (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_wr      (cmd_wr),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_wstrb   (cmd_wstrb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_wr      (rsp_wr),
        .rsp_rdata   (rsp_rdata),
        .rsp_resp    (rsp_resp),
        .rsp_timeout (rsp_timeout),
        .AWADDR      (AWADDR),
        .AWPROT      (AWPROT),
        .AWVALID     (AWVALID),
        .AWREADY     (AWREADY),
        .WDATA       (WDATA),
        .WSTRB       (WSTRB),
        .WVALID      (WVALID),
        .WREADY      (WREADY),
        .BRESP       (BRESP),
        .BVALID      (BVALID),
        .BREADY      (BREADY),
        .ARADDR      (ARADDR),
        .ARPROT      (ARPROT),
        .ARVALID     (ARVALID),
        .ARREADY     (ARREADY),
        .RDATA       (RDATA),
        .RRESP       (RRESP),
        .RVALID      (RVALID),
        .RREADY      (RREADY)
    );

    typedef struct {
        logic          wr;
        logic [DW-1:0] rdata;
        logic [1:0]    resp;
        logic          to;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Scoreboard monitor: compare each presented response with the queue head.
    always @(negedge ACLK) begin
        if (ARESETN && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got wr=%0d resp=%0h with no response expected", rsp_wr, rsp_resp);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_wr", rsp_wr, e.wr);
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_resp", rsp_resp, e.resp);
                chk("rsp_timeout", rsp_timeout, e.to);
                $display("rsp: wr=%0d rdata=%08h resp=%0d timeout=%0d", rsp_wr, rsp_rdata, rsp_resp, rsp_timeout);
            end
        end
    end

    // Stability monitor: a VALID not handshaken must hold with unchanged payload.
    logic          p_rstn = 1'b0;
    logic          p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rv, p_rr;
    logic [AW-1:0] p_awaddr, p_araddr;
    logic [DW-1:0] p_wdata, p_rdata;
    logic [1:0]    p_resp;
    always @(negedge ACLK) begin
        if (ARESETN && p_rstn) begin
            if (p_awv && !p_awr) begin
                chk("awvalid_hold", AWVALID, 1'b1);
                chk("awaddr_hold", AWADDR, p_awaddr);
            end
            if (p_wv && !p_wr) begin
                chk("wvalid_hold", WVALID, 1'b1);
                chk("wdata_hold", WDATA, p_wdata);
            end
            if (p_arv && !p_arr) begin
                chk("arvalid_hold", ARVALID, 1'b1);
                chk("araddr_hold", ARADDR, p_araddr);
            end
            if (p_rv && !p_rr) begin
                chk("rsp_valid_hold", rsp_valid, 1'b1);
                chk("rsp_rdata_hold", rsp_rdata, p_rdata);
                chk("rsp_resp_hold", rsp_resp, p_resp);
            end
        end
        p_rstn   = ARESETN;
        p_awv    = AWVALID; p_awr = AWREADY; p_awaddr = AWADDR;
        p_wv     = WVALID;  p_wr  = WREADY;  p_wdata  = WDATA;
        p_arv    = ARVALID; p_arr = ARREADY; p_araddr = ARADDR;
        p_rv     = rsp_valid; p_rr = rsp_ready;
        p_rdata  = rsp_rdata; p_resp = rsp_resp;
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Wait (bounded) for cmd_ready, then present one command for one cycle.
    task automatic send_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [3:0] strb, input bit push, input exp_t e);
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        chk("cmd_ready_wait", cmd_ready, 1'b1);
        if (push) exp_q.push_back(e);
        $display("cmd: wr=%0d addr=%08h wdata=%08h strb=%0h", wr, addr, data, strb);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_wstrb = strb;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic chk_all_idle(input string tag);
        chk({tag, "_awvalid"}, AWVALID, 1'b0);
        chk({tag, "_wvalid"}, WVALID, 1'b0);
        chk({tag, "_arvalid"}, ARVALID, 1'b0);
        chk({tag, "_bready"}, BREADY, 1'b0);
        chk({tag, "_rready"}, RREADY, 1'b0);
        chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        chk({tag, "_rsp_timeout"}, rsp_timeout, 1'b0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
        chk({tag, "_rsp_resp"}, rsp_resp, 2'b00);
        chk({tag, "_rsp_wr"}, rsp_wr, 1'b0);
    endtask

    initial begin
        exp_t e;
        ARESETN = 1'b0;
        cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b1;
        AWREADY = 1'b0; WREADY = 1'b0; ARREADY = 1'b0;
        BVALID = 1'b0; BRESP = 2'b00;
        RVALID = 1'b0; RDATA = '0; RRESP = 2'b00;

        // Reset state
        #2;
        chk("reset_cmd_ready", cmd_ready, 1'b0);
        chk_all_idle("reset");
        chk("awprot", AWPROT, 3'b000);
        chk("arprot", ARPROT, 3'b000);
        tick();
        tick();
        ARESETN = 1'b1;
        #1;
        chk("post_reset_cmd_ready", cmd_ready, 1'b1);
        tick();

        // Write, slave always ready, OKAY
        AWREADY = 1'b1; WREADY = 1'b1;
        e = '{wr: 1'b1, rdata: 32'h0, resp: 2'b00, to: 1'b0};
        send_cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, e);
        chk("w1_awvalid", AWVALID, 1'b1);
        chk("w1_wvalid", WVALID, 1'b1);
        chk("w1_awaddr", AWADDR, 32'h0000_0010);
        chk("w1_wdata", WDATA, 32'hDEAD_BEEF);
        chk("w1_wstrb", WSTRB, 4'hF);
        chk("w1_cmd_ready", cmd_ready, 1'b0);
        tick();
        chk("w1_awvalid_drop", AWVALID, 1'b0);
        chk("w1_wvalid_drop", WVALID, 1'b0);
        chk("w1_bready", BREADY, 1'b1);
        BVALID = 1'b1; BRESP = 2'b00;
        tick();
        BVALID = 1'b0;
        chk("w1_bready_drop", BREADY, 1'b0);
        chk("w1_rsp_valid", rsp_valid, 1'b1);
        tick();
        chk("w1_back_idle", cmd_ready, 1'b1);

        // Write, W accepted three cycles ahead of AW, early BVALID
        AWREADY = 1'b0; WREADY = 1'b0;
        e = '{wr: 1'b1, rdata: 32'h0, resp: 2'b01, to: 1'b0};
        send_cmd(1'b1, 32'h0000_0044, 32'hCAFE_F00D, 4'h3, 1'b1, e);
        chk("w2_awvalid", AWVALID, 1'b1);
        chk("w2_wvalid", WVALID, 1'b1);
        WREADY = 1'b1;
        tick();
        WREADY = 1'b0;
        chk("w2_wvalid_drop", WVALID, 1'b0);
        chk("w2_awvalid_held", AWVALID, 1'b1);
        BVALID = 1'b1; BRESP = 2'b01;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("w2_awvalid_wait", AWVALID, 1'b1);
            chk("w2_awaddr_wait", AWADDR, 32'h0000_0044);
            chk("w2_bready_early", BREADY, 1'b0);
            chk("w2_wvalid_low", WVALID, 1'b0);
        end
        AWREADY = 1'b1;
        tick();
        AWREADY = 1'b0;
        chk("w2_awvalid_drop", AWVALID, 1'b0);
        chk("w2_bready", BREADY, 1'b1);
        tick();
        BVALID = 1'b0;
        chk("w2_rsp_valid", rsp_valid, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        chk("w2_single_rsp", exp_q.size(), 0);
        chk("w2_rsp_idle", rsp_valid, 1'b0);

        // Read, ARREADY late, SLVERR with data, early RVALID
        e = '{wr: 1'b0, rdata: 32'h1234_5678, resp: 2'b10, to: 1'b0};
        send_cmd(1'b0, 32'h0000_0020, 32'h0, 4'h0, 1'b1, e);
        chk("r1_arvalid", ARVALID, 1'b1);
        chk("r1_araddr", ARADDR, 32'h0000_0020);
        chk("r1_awvalid", AWVALID, 1'b0);
        RVALID = 1'b1; RDATA = 32'h1234_5678; RRESP = 2'b10;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("r1_arvalid_wait", ARVALID, 1'b1);
            chk("r1_rready_early", RREADY, 1'b0);
        end
        ARREADY = 1'b1;
        tick();
        ARREADY = 1'b0;
        chk("r1_arvalid_drop", ARVALID, 1'b0);
        chk("r1_rready", RREADY, 1'b1);
        tick();
        RVALID = 1'b0;
        chk("r1_rsp_valid", rsp_valid, 1'b1);
        chk("r1_rready_drop", RREADY, 1'b0);
        tick();

        // Read with RVALID withheld past the timeout
        ARREADY = 1'b1;
        e = '{wr: 1'b0, rdata: 32'hA5A5_0000, resp: 2'b00, to: 1'b1};
        send_cmd(1'b0, 32'h0000_0030, 32'h0, 4'h0, 1'b1, e);
        chk("to_start", rsp_timeout, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) ARREADY = 1'b0;
            chk($sformatf("to_cycle%0d", k), rsp_timeout, (k >= TO) ? 1'b1 : 1'b0);
        end
        RVALID = 1'b1; RDATA = 32'hA5A5_0000; RRESP = 2'b00;
        tick();
        RVALID = 1'b0;
        chk("to_rsp_valid", rsp_valid, 1'b1);
        tick();
        chk("to_sticky_idle", rsp_timeout, 1'b1);

        // Write with response back-pressure; commands offered while busy are ignored
        rsp_ready = 1'b0;
        AWREADY = 1'b1; WREADY = 1'b1;
        e = '{wr: 1'b1, rdata: 32'h0, resp: 2'b11, to: 1'b0};
        send_cmd(1'b1, 32'h0000_0050, 32'h0BAD_C0DE, 4'hC, 1'b1, e);
        chk("bp_timeout_cleared", rsp_timeout, 1'b0);
        tick();
        BVALID = 1'b1; BRESP = 2'b11;
        tick();
        BVALID = 1'b0;
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h0000_0999;
        for (int i = 0; i < 10; i++) begin
            chk("bp_rsp_valid", rsp_valid, 1'b1);
            chk("bp_rsp_resp", rsp_resp, 2'b11);
            chk("bp_rsp_wr", rsp_wr, 1'b1);
            chk("bp_cmd_ready", cmd_ready, 1'b0);
            tick();
        end
        cmd_valid = 1'b0;
        chk("bp_addr_kept", AWADDR, 32'h0000_0050);
        chk("bp_no_read", ARVALID, 1'b0);
        rsp_ready = 1'b1;
        tick();
        chk("bp_rsp_done", rsp_valid, 1'b0);
        chk("bp_cmd_ready_back", cmd_ready, 1'b1);

        // Reset pulse while waiting for B: no response for the aborted command
        e = '{wr: 1'b1, rdata: 32'h0, resp: 2'b00, to: 1'b0};
        send_cmd(1'b1, 32'h0000_0060, 32'h5555_AAAA, 4'hF, 1'b0, e);
        tick();
        chk("rst_bready_before", BREADY, 1'b1);
        #2;
        ARESETN = 1'b0;
        BVALID = 1'b1; BRESP = 2'b00;
        #1;
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk_all_idle("rst_async");
        tick();
        chk_all_idle("rst_hold");
        ARESETN = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_no_rsp", rsp_valid, 1'b0);
            chk("rst_bready_after", BREADY, 1'b0);
            chk("rst_cmd_ready_after", cmd_ready, 1'b1);
        end
        BVALID = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard bound on run time in case the DUT stalls somewhere unexpected.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
